// File: rtl/alu_nibble_seq_if.sv
// Handshake and operand/result bundle for the nibble-serial ALU sequencer.
// The master is the control unit and the slave is alu_nibble_seq.
interface alu_nibble_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovr;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, co, ovr, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, co, ovr, zero
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU: one 4-bit slice is reused over WIDTH/4 cycles, and the carry is registered between cycles.
// Optional macro ALU_SLT_OVF_FIX_EN corrects the SLT result bit when the subtraction overflows.
module alu_nibble_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_nibble_seq_if.slave bus
);
  localparam int NNIB = WIDTH / 4;
  localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDXW-1:0]  idx_r;
  logic             c_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             done_r;
  logic             co_r;
  logic             ovr_r;
  logic             zero_r;

  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [3:0]       bx_s;
  logic [1:0]       sel_s;
  logic             slt_s;
  logic [4:0]       carry_s;
  logic [3:0]       sum_s;
  logic [3:0]       slice_res_s;
  logic             slice_set_s;
  logic             slice_co_s;
  logic             slice_ovr_s;
  logic             slt_bit_s;
  logic             last_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] res_final_s;

  // Operand nibble selection and opcode decode for the current iteration
  always_comb begin
    a_nib_s = a_r[{idx_r, 2'b00} +: 4];
    b_nib_s = b_r[{idx_r, 2'b00} +: 4];
    slt_s   = (op_r[1:0] == 2'b11);
    last_s  = (idx_r == IDXW'(NNIB - 1));
    if (slt_s) begin
      sel_s = 2'b10;
    end else begin
      sel_s = op_r[1:0];
    end
  end

  // 4-bit ALU slice (upper-slice variant): less inputs tied low, provides set/co/overflow
  always_comb begin
    carry_s    = 5'b00000;
    sum_s      = 4'b0000;
    carry_s[0] = c_r;
    if (op_r[2]) begin
      bx_s = ~b_nib_s;
    end else begin
      bx_s = b_nib_s;
    end
    for (int i = 0; i < 4; i++) begin
      sum_s[i]       = a_nib_s[i] ^ bx_s[i] ^ carry_s[i];
      carry_s[i + 1] = (a_nib_s[i] & bx_s[i]) | (carry_s[i] & (a_nib_s[i] ^ bx_s[i]));
    end
    case (sel_s)
      2'b00:   slice_res_s = a_nib_s & bx_s;
      2'b01:   slice_res_s = a_nib_s | bx_s;
      2'b10:   slice_res_s = sum_s;
      default: slice_res_s = 4'b0000;
    endcase
    slice_set_s = sum_s[3];
    slice_co_s  = carry_s[4];
    slice_ovr_s = carry_s[3] ^ carry_s[4];
  end

  // SLT bit selection and next/final result assembly
  always_comb begin
`ifdef ALU_SLT_OVF_FIX_EN
    slt_bit_s = slice_set_s ^ slice_ovr_s;
`else
    slt_bit_s = slice_set_s;
`endif
    res_next_s = result_r;
    if (slt_s) begin
      res_next_s[{idx_r, 2'b00} +: 4] = 4'b0000;
    end else begin
      res_next_s[{idx_r, 2'b00} +: 4] = slice_res_s;
    end
    if (slt_s) begin
      res_final_s    = {WIDTH{1'b0}};
      res_final_s[0] = slt_bit_s;
    end else begin
      res_final_s = res_next_s;
    end
  end

  // Sequencer FSM with operand latching, carry chaining and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {IDXW{1'b0}};
      c_r      <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      op_r     <= 3'b000;
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      co_r     <= 1'b0;
      ovr_r    <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            op_r    <= bus.op;
            idx_r   <= {IDXW{1'b0}};
            c_r     <= bus.op[2];
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          c_r <= slice_co_s;
          if (last_s) begin
            result_r <= res_final_s;
            co_r     <= slice_co_s;
            ovr_r    <= slice_ovr_s;
            zero_r   <= (res_final_s == {WIDTH{1'b0}});
            idx_r    <= {IDXW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            result_r <= res_next_s;
            idx_r    <= idx_r + 1'b1;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            state_r  <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          idx_r   <= {IDXW{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.co     = co_r;
  assign bus.ovr    = ovr_r;
  assign bus.zero   = zero_r;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed, table-driven bench for alu_nibble_seq (WIDTH=32) plus hand-written multi-cycle sequences.
module tb_alu_nibble_seq;
  localparam int WIDTH = 32;
  localparam int NNIB  = WIDTH / 4;
`ifdef ALU_SLT_OVF_FIX_EN
  localparam logic SLT_FIX = 1'b1;
`else
  localparam logic SLT_FIX = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        ovr;
    logic        zero;
    logic        flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_nibble_seq_if #(.WIDTH(WIDTH)) bus ();
  alu_nibble_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pulses start for one edge; returns at the negedge of cycle 0 after the start edge
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = ~op; bus.a = ~a; bus.b = ~b;
  endtask

  // Scans cycles from the current one (k0) until done; counts busy-profile errors
  task automatic wait_done(input int k0, output int lat, output int bad_busy);
    lat = -1;
    bad_busy = 0;
    for (int k = k0; k < k0 + 20; k++) begin
      if (k > k0) @(negedge clk);
      if (bus.busy !== ((k < NNIB) ? 1'b1 : 1'b0)) bad_busy++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bad, ndone;
    logic [31:0] held;

    vecs[0]  = '{op:3'b010, a:32'h0000_000F, b:32'h0000_0001, res:32'h0000_0010, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b1};
    vecs[1]  = '{op:3'b110, a:32'h1234_5678, b:32'h1234_5678, res:32'h0000_0000, co:1'b1, ovr:1'b0, zero:1'b1, flags:1'b1};
    vecs[2]  = '{op:3'b010, a:32'h7FFF_FFFF, b:32'h0000_0001, res:32'h8000_0000, co:1'b0, ovr:1'b1, zero:1'b0, flags:1'b1};
    vecs[3]  = '{op:3'b111, a:32'h8000_0000, b:32'h0000_0001, res:{31'd0, SLT_FIX}, co:1'b1, ovr:1'b1, zero:~SLT_FIX, flags:1'b1};
    vecs[4]  = '{op:3'b111, a:32'h0000_0005, b:32'h0000_0009, res:32'h0000_0001, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b1};
    vecs[5]  = '{op:3'b000, a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, res:32'h00F0_00F0, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b0};
    vecs[6]  = '{op:3'b001, a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, res:32'hFFF0_FFF0, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b0};
    vecs[7]  = '{op:3'b100, a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, res:32'hF000_F000, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b0};
    vecs[8]  = '{op:3'b101, a:32'hF0F0_F0F0, b:32'h0FF0_0FF0, res:32'hF0FF_F0FF, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b0};
    vecs[9]  = '{op:3'b010, a:32'hFFFF_FFFF, b:32'h0000_0001, res:32'h0000_0000, co:1'b1, ovr:1'b0, zero:1'b1, flags:1'b1};
    vecs[10] = '{op:3'b110, a:32'h0000_0000, b:32'h0000_0001, res:32'hFFFF_FFFF, co:1'b0, ovr:1'b0, zero:1'b0, flags:1'b1};
    vecs[11] = '{op:3'b011, a:32'h0000_0005, b:32'h0000_0009, res:32'h0000_0000, co:1'b0, ovr:1'b0, zero:1'b1, flags:1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.a = 32'h0; bus.b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_co", {31'd0, bus.co}, 32'd0);
    chk("rst_ovr", {31'd0, bus.ovr}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, bad);
      chk($sformatf("v%0d_latency", i), lat, NNIB);
      chk($sformatf("v%0d_busy", i), bad, 32'd0);
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].zero});
      if (vecs[i].flags) begin
        chk($sformatf("v%0d_co", i), {31'd0, bus.co}, {31'd0, vecs[i].co});
        chk($sformatf("v%0d_ovr", i), {31'd0, bus.ovr}, {31'd0, vecs[i].ovr});
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("v%0d_busy_after", i), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("v%0d_result_hold", i), bus.result, vecs[i].res);
    end

    // Second start during RUN must be ignored
    start_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4, lat, bad);
    chk("ign_latency", lat, NNIB);
    chk("ign_result", bus.result, 32'h00F0_00F0);
    held = bus.result;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("ign_extra_done", ndone, 32'd0);
    chk("ign_result_hold", bus.result, held);

    // Reset mid-RUN aborts without a done pulse
    start_op(3'b010, 32'h1111_1111, 32'h0000_0001);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_zero", {31'd0, bus.zero}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    start_op(3'b010, 32'd2, 32'd3);
    wait_done(0, lat, bad);
    chk("post_abort_latency", lat, NNIB);
    chk("post_abort_result", bus.result, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Nibble-serial ALU sequencer for the MIPS datapath.
- Performs a WIDTH-bit ALU operation by time-multiplexing one instance of the existing 4-bit ALU slice (the upper-slice variant that provides carry-out, set and overflow) over WIDTH/4 cycles.
- Handles operand latching, nibble selection, carry chaining between cycles, and SLT post-processing. Reports result and flags with a start/busy/done handshake.
- Sits between the control unit and the register-file writeback path, in place of a full-width combinational ALU, on area-constrained builds.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of 4 and at least 8.
- NNIB, WIDTH/4, number of nibble iterations (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  3  {binv, sel1, sel0}: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. 011 is SLT without inversion; 100/101 are AND/OR with B inverted.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high while the operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  registered result. Holds its value until the next accepted start.
- co  out  1  carry-out of the final nibble.
- ovr  out  1  signed overflow of the final nibble (carry into MSB xor carry out of MSB).
- zero  out  1  high when result == 0. Registered together with done.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE; busy=0, done=0, result=0, co=0, ovr=0, zero=1; nibble index, carry register and operand registers cleared.
- FSM IDLE -> RUN: on start=1. a, b and op are latched; nibble index idx=0; carry register c=op[2] (binv provides the +1 for SUB/SLT). busy goes high at the same edge.
- RUN, each cycle:
  - The slice is driven with the latched a/b nibble idx, cin=c, binv=op[2]. sel=op[1:0], except SLT (sel=11), which drives sel=10 (add). All less inputs are tied to 0.
  - At the clock edge: c <= slice co. Result nibble idx <= slice result, or 0 when op is SLT. idx <= idx+1.
- RUN -> DONE: at the edge that registers nibble NNIB-1.
  - co and ovr are captured from the slice outputs for that final nibble.
  - For SLT, result[0] <= slice set; all other result bits stay 0.
  - zero is computed from the final result value.
  - busy drops; done=1 for exactly the one DONE cycle.
- DONE -> IDLE: unconditionally, on the next edge.
- Latency: start sampled at edge E; done is high in the cycle following edge E+NNIB (8 cycles for WIDTH=32). Throughput is one operation per NNIB+2 cycles.
- Flags:
  - co and ovr are meaningful for ADD/SUB/SLT.
  - For AND/OR they reflect the final-nibble adder path and must be ignored by consumers.
  - Flags are not updated during RUN.
- Boundary conditions:
  - start during RUN or DONE is ignored, with no queuing.
  - a, b and op changes after acceptance have no effect.
  - rst asserted mid-RUN aborts the operation at that edge and applies the reset values; no done pulse is generated.
  - idx wraps only via the FSM and never exceeds NNIB-1.
  - Carry between nibbles is purely registered; the slice is never chained combinationally.

Optional Feature:
- Macro: ALU_SLT_OVF_FIX_EN.
- Defined: the SLT result bit is set xor ovr of the final nibble, giving a correct signed less-than even when the subtraction overflows.
- Undefined: the SLT result bit is the raw set (MSB of A-B), matching the legacy full-width ALU, which is incorrect on overflow.
- No other behaviour, latency or port changes.

Test Plan:
- ADD: a=32'h0000_000F, b=32'h0000_0001, op=010, start -> done exactly 8 cycles after the start edge. result=32'h0000_0010, co=0, ovr=0, zero=0; busy high for cycles 0-7 after the start edge.
- SUB carry/zero: a=b=32'h1234_5678, op=110 -> result=0, zero=1, co=1, ovr=0.
- Overflow: a=32'h7FFF_FFFF, b=32'h0000_0001, op=010 -> result=32'h8000_0000, ovr=1, co=0.
- SLT with overflow: a=32'h8000_0000, b=32'h0000_0001, op=111.
  - Macro defined -> result=1.
  - Macro undefined -> result=0.
  - Also a=5, b=9 -> result=1 in both builds.
- Logic ops plus ignored start: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0.
  - AND -> 32'h00F0_00F0. OR -> 32'hFFF0_FFF0.
  - A second start pulsed mid-RUN produces no extra done pulse, and result equals the first operation.
- Reset abort: start ADD, assert rst for 1 cycle at RUN cycle 3 -> no done pulse. Next cycle: busy=0, result=0, zero=1. A following ADD 2+3 -> result=5.
